// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch unit with a small prefetch queue.
// A synchronous instruction memory feeds a QueueDepth-entry FIFO that
// decode drains through a valid/ready handshake. Redirects flush the
// queue and any read in flight, then restart fetch at the new address.
// Build option: define FETCH_MISALIGN_FAULT_EN to trap redirects to a
// non word-aligned address in a FAULT state instead of silently aligning.
module fetch_prefetch #(
    parameter logic [31:0] ResetVector  = 32'h8000_0000,
    parameter int          IMemDepth    = 2048,
    parameter int          QueueDepth   = 4,
    parameter string       IMemInitFile = "imem.mem"
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        instr_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int AddrW = $clog2(IMemDepth);
    localparam int PtrW  = $clog2(QueueDepth);
    localparam int CntW  = PtrW + 1;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FAULT
    } state_e;

    state_e          state_q;
    logic [31:0]     pc_q;
    logic            inflight_q;
    logic [31:0]     inflight_pc_q;
    logic [31:0]     rdata_q;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;

    logic [31:0] imem    [IMemDepth];
    logic [31:0] q_instr [QueueDepth];
    logic [31:0] q_pc    [QueueDepth];

    logic            redirect_ok;
    logic [31:0]     target_pc;
    logic [CntW-1:0] occ_sum;
    logic            issue;
    logic            push;
    logic            pop;

`ifdef FETCH_MISALIGN_FAULT_EN
    logic        fault_q;
    logic [31:0] fault_pc_q;

    assign fault_o    = fault_q;
    assign fault_pc_o = fault_pc_q;
`else
    // Low address bits are dropped when targets are forced word-aligned.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign fault_o    = 1'b0;
    assign fault_pc_o = 32'h0;
`endif

    // Handshake decode: redirect target, issue/push/pop enables.
    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        redirect_ok = 1'b1;
`ifdef FETCH_MISALIGN_FAULT_EN
        target_pc   = redirect_pc_i;
        redirect_ok = (redirect_pc_i[1:0] == 2'b00);
`else
        target_pc   = {redirect_pc_i[31:2], 2'b00};
`endif
        occ_sum = count_q + CntW'(inflight_q);
        issue   = (state_q == RUN) && !redirect_i && (occ_sum < CntW'(QueueDepth));
        push    = inflight_q && !redirect_i;
        pop     = instr_valid_o && instr_ready_i;
    end

    // Fetch FSM, fetch pc, in-flight tracking and queue pointers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= BOOT;
            pc_q          <= ResetVector;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
`ifdef FETCH_MISALIGN_FAULT_EN
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
`endif
        end else if (redirect_i) begin
            // Redirect wins over push and issue: flush everything, reload pc.
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            pc_q       <= target_pc;
            state_q    <= redirect_ok ? RUN : FAULT;
`ifdef FETCH_MISALIGN_FAULT_EN
            if (redirect_ok) begin
                fault_q <= 1'b0;
            end else begin
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc_i;
            end
`endif
        end else begin
            if (state_q == BOOT) state_q <= RUN;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 32'd4;
            end
            if (push) tail_q <= tail_q + PtrW'(1);
            if (pop)  head_q <= head_q + PtrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Synchronous instruction memory read; the index truncates the pc so addresses alias.
    // NOTE: memory arrays carry no reset; validity is tracked by the reset control bits instead.
    always_ff @(posedge clk_i) begin
        if (issue) rdata_q <= imem[pc_q[AddrW+1:2]];
    end

    // Queue storage: write the returning word and its pc at the tail.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[tail_q] <= rdata_q;
            q_pc[tail_q]    <= inflight_pc_q;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? q_instr[head_q] : 32'h0;
    assign pc_o          = instr_valid_o ? q_pc[head_q]    : 32'h0;

endmodule
